branch_pred_unit: RTL and testbench
===================================

BRANCH_PRED_UNIT -- requirements
Module: branch_pred_unit

Interface
REQ-001 SHALL have parameter DBITS, default 32, meaning instruction address and target width.
REQ-002 SHALL have parameter PTINDEXBITS, default 8, meaning pattern-table index width; the BHR width equals this value.
REQ-003 SHALL have parameter BTBINDEXBITS, default 6, meaning BTB index width, with BTBINDEXBITS <= PTINDEXBITS.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 fe_req  in  1  FE lookup valid this cycle.
REQ-007 fe_pc  in  DBITS  PC being fetched.
REQ-008 pred_taken  out  1  predict redirect.
REQ-009 pred_target  out  DBITS  predicted next PC.
REQ-010 pred_pt_idx  out  PTINDEXBITS  PT index used, carried down the pipe to AGEX.
REQ-011 upd_valid  in  1  resolved control-flow instruction from AGEX.
REQ-012 upd_pc  in  DBITS  PC of the resolved instruction.
REQ-013 upd_pt_idx  in  PTINDEXBITS  PT index returned from pred_pt_idx.
REQ-014 upd_is_cond  in  1  1 = conditional branch, 0 = unconditional jump.
REQ-015 upd_taken  in  1  resolved direction.
REQ-016 upd_target  in  DBITS  resolved target.
REQ-017 ready  out  1  table initialisation complete.

Function
REQ-018 The block SHALL compute pred_pt_idx = fe_pc[PTINDEXBITS+1:2] XOR BHR, btb_idx = fe_pc[BTBINDEXBITS+1:2] and tag = fe_pc[DBITS-1:BTBINDEXBITS+2].
REQ-019 Lookup SHALL be combinational, with zero-cycle latency, and SHALL use pre-edge table and BHR state; no same-cycle update bypass.
REQ-020 BTB hit SHALL be defined as entry valid AND stored tag == tag.
REQ-021 pred_taken SHALL be asserted when fe_req & ready & hit & (entry uncond bit OR PT[pred_pt_idx][1]).
REQ-022 pred_target SHALL be the BTB target when pred_taken=1, else fe_pc+4 (modulo 2^DBITS).
REQ-023 A PT entry SHALL be a 2-bit saturating counter: 00/01 predict not-taken, 10/11 predict taken.
REQ-024 On upd_valid & ready & upd_is_cond, PT[upd_pt_idx] SHALL increment if upd_taken and decrement otherwise, saturating at 11 and 00.
REQ-025 On upd_valid & ready & upd_is_cond, BHR SHALL become {BHR[PTINDEXBITS-2:0], upd_taken}.
REQ-026 Unconditional updates SHALL leave PT and BHR unchanged.
REQ-027 On upd_valid & ready & (upd_taken | ~upd_is_cond), BTB[upd_pc idx] SHALL be written as {valid=1, tag(upd_pc), upd_target, uncond=~upd_is_cond}, overwriting any aliased entry.
REQ-028 A not-taken conditional update SHALL NOT modify the BTB.
REQ-029 The FSM SHALL have two states, INIT and RUN.
REQ-030 In INIT, each cycle SHALL write PT[init_cnt]=01, clear BTB valid[init_cnt] when init_cnt < 2^BTBINDEXBITS, and increment init_cnt.
REQ-031 When init_cnt == 2^PTINDEXBITS-1, the FSM SHALL transition INIT->RUN on that edge; RUN SHALL be held until reset.
REQ-032 ready SHALL be 1 exactly in RUN; INIT SHALL last 2^PTINDEXBITS cycles (256 at the defaults).
REQ-033 Updates SHALL be ignored in INIT, and pred_taken SHALL be 0 in INIT.
REQ-034 A lookup and an update in the same cycle to the same entry SHALL make the lookup see the old value and the update commit at the edge.

Reset
REQ-035 reset high at a clock edge SHALL set state=INIT, init_cnt=0 and BHR=0, from any state including mid-INIT.
REQ-036 While reset is high: ready=0, pred_taken=0, pred_target=fe_pc+4.
REQ-037 Table contents are not cleared by reset itself; they SHALL be cleared only by the INIT sweep.

Verification
REQ-038 Reset 1 cycle then release -> ready=0 for 256 cycles, then 1; pred_taken=0 for any fe_pc throughout.
REQ-039 After ready, update pc=0x100, is_cond=0, target=0x300 -> next lookup at 0x100: pred_taken=1, pred_target=0x300; BHR stays 0.
REQ-040 Cond updates at upd_pt_idx=5 with taken, taken, taken, taken -> counter 10, 11, 11, 11; then not-taken twice -> 10, 01.
REQ-041 Install pc=0x100 jump, then look up 0x200 (same btb_idx 0, different tag) -> miss, pred_target=0x204.
REQ-042 Install 0x100 entry, reset 1 cycle, wait 256 cycles -> lookup 0x100 misses; BHR=0; an update issued during INIT has no effect.
REQ-043 Cond taken update with BHR=0 at pc=0x100 -> BHR=0x01; next lookup 0x100 gives pred_pt_idx=0x41 and pred_taken=0 (counter at 01).

Source files
------------

// File: rtl/branch_pred_unit.sv
// Branch prediction unit: gshare direction predictor (2-bit counters indexed by
// PC xor global history) plus a direct-mapped BTB. Lookup is combinational
// against pre-edge state; resolved branches from AGEX update the tables on the
// clock edge. After reset an INIT sweep clears the tables before ready rises.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   fe_req, fe_pc       fetch-stage lookup request and PC
//   pred_taken          redirect fetch to pred_target
//   pred_target         BTB target when predicted taken, else fe_pc+4
//   pred_pt_idx         pattern-table index used, returned later as upd_pt_idx
//   upd_*               resolved control-flow instruction from AGEX
//   ready               table initialisation complete
module branch_pred_unit #(
   parameter int unsigned DBITS        = 32,
   parameter int unsigned PTINDEXBITS  = 8,
   parameter int unsigned BTBINDEXBITS = 6
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   fe_req,
   input  logic [DBITS-1:0]       fe_pc,
   output logic                   pred_taken,
   output logic [DBITS-1:0]       pred_target,
   output logic [PTINDEXBITS-1:0] pred_pt_idx,
   input  logic                   upd_valid,
   input  logic [DBITS-1:0]       upd_pc,
   input  logic [PTINDEXBITS-1:0] upd_pt_idx,
   input  logic                   upd_is_cond,
   input  logic                   upd_taken,
   input  logic [DBITS-1:0]       upd_target,
   output logic                   ready
);

   localparam int unsigned PT_ENTRIES  = 1 << PTINDEXBITS;
   localparam int unsigned BTB_ENTRIES = 1 << BTBINDEXBITS;
   localparam int unsigned TAGBITS     = DBITS - BTBINDEXBITS - 2;
   localparam logic [PTINDEXBITS:0] BTB_LIMIT = (PTINDEXBITS+1)'(BTB_ENTRIES);

   typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

   state_t                   state;
   logic [PTINDEXBITS-1:0]   init_cnt;
   logic [PTINDEXBITS-1:0]   bhr;

   // Tables carry no reset; only the INIT sweep clears them.
   logic [1:0]               pt         [PT_ENTRIES];
   logic                     btb_valid  [BTB_ENTRIES];
   logic [TAGBITS-1:0]       btb_tag    [BTB_ENTRIES];
   logic [DBITS-1:0]         btb_target [BTB_ENTRIES];
   logic                     btb_uncond [BTB_ENTRIES];

   logic [BTBINDEXBITS-1:0]  lu_btb_idx;
   logic [TAGBITS-1:0]       lu_tag;
   logic                     lu_hit;
   logic [BTBINDEXBITS-1:0]  up_btb_idx;
   logic [TAGBITS-1:0]       up_tag;
   logic                     upd_en;
   logic [1:0]               pt_cur;
   logic [1:0]               pt_next;
   logic                     unused_pc_bits;

   // Byte-offset bits never take part in indexing.
   assign unused_pc_bits = ^{fe_pc[1:0], upd_pc[1:0]};

   // Gated by reset so a RUN-state block reads as not ready while held in reset.
   assign ready = (state == RUN) && !reset;

   // Lookup path
   assign pred_pt_idx = fe_pc[PTINDEXBITS+1:2] ^ bhr;
   assign lu_btb_idx  = fe_pc[BTBINDEXBITS+1:2];
   assign lu_tag      = fe_pc[DBITS-1:BTBINDEXBITS+2];
   assign lu_hit      = btb_valid[lu_btb_idx] && (btb_tag[lu_btb_idx] == lu_tag);
   assign pred_taken  = fe_req && ready && lu_hit &&
                        (btb_uncond[lu_btb_idx] || pt[pred_pt_idx][1]);
   assign pred_target = pred_taken ? btb_target[lu_btb_idx] : fe_pc + DBITS'(4);

   // Update path
   assign upd_en     = upd_valid && ready;
   assign up_btb_idx = upd_pc[BTBINDEXBITS+1:2];
   assign up_tag     = upd_pc[DBITS-1:BTBINDEXBITS+2];
   assign pt_cur     = pt[upd_pt_idx];

   // Saturating 2-bit counter step
   always_comb begin
      pt_next = pt_cur;
      if (upd_taken) begin
         if (pt_cur != 2'b11) pt_next = pt_cur + 2'd1;
      end else begin
         if (pt_cur != 2'b00) pt_next = pt_cur - 2'd1;
      end
   end

   // Control state: INIT sweep counter, FSM and global history
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= INIT;
         init_cnt <= '0;
         bhr      <= '0;
      end else begin
         case (state)
            INIT: begin
               init_cnt <= init_cnt + PTINDEXBITS'(1);
               if (init_cnt == '1) state <= RUN;
            end
            RUN: begin
               if (upd_en && upd_is_cond) bhr <= {bhr[PTINDEXBITS-2:0], upd_taken};
            end
            default: state <= INIT;
         endcase
      end
   end

   // Table writes: INIT sweep, or resolved-branch update in RUN
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         pt[init_cnt] <= 2'b01;
         if ({1'b0, init_cnt} < BTB_LIMIT)
            btb_valid[init_cnt[BTBINDEXBITS-1:0]] <= 1'b0;
      end else if (upd_en) begin
         if (upd_is_cond) pt[upd_pt_idx] <= pt_next;
         // Not-taken conditionals leave the BTB alone.
         if (upd_taken || !upd_is_cond) begin
            btb_valid[up_btb_idx]  <= 1'b1;
            btb_tag[up_btb_idx]    <= up_tag;
            btb_target[up_btb_idx] <= upd_target;
            btb_uncond[up_btb_idx] <= !upd_is_cond;
         end
      end
   end

endmodule

// File: tb/tb_branch_pred_unit.sv
// Self-checking bench for branch_pred_unit at default parameters.
module tb_branch_pred_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        fe_req;
   logic [31:0] fe_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic [7:0]  pred_pt_idx;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [7:0]  upd_pt_idx;
   logic        upd_is_cond;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        ready;

   always #5 clk = ~clk;

   branch_pred_unit #(.DBITS(32), .PTINDEXBITS(8), .BTBINDEXBITS(6)) dut (
      .clk(clk), .reset(reset), .fe_req(fe_req), .fe_pc(fe_pc),
      .pred_taken(pred_taken), .pred_target(pred_target), .pred_pt_idx(pred_pt_idx),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_pt_idx(upd_pt_idx),
      .upd_is_cond(upd_is_cond), .upd_taken(upd_taken), .upd_target(upd_target),
      .ready(ready)
   );

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      string       name;
      logic        taken;
      logic [31:0] target;
      logic [7:0]  idx;
   } exp_t;

   exp_t exp_q[$];

   // Reference model of predictor state
   logic [1:0]  m_pt  [256];
   logic        m_bv  [64];
   logic [23:0] m_tag [64];
   logic [31:0] m_tgt [64];
   logic        m_unc [64];
   logic [7:0]  m_bhr;
   logic        m_ready = 1'b0;

   function automatic exp_t mk(input string name, input logic tk, input logic [31:0] tgt,
                               input logic [7:0] idx);
      exp_t e;
      e.name = name; e.taken = tk; e.target = tgt; e.idx = idx;
      return e;
   endfunction

   function automatic exp_t m_predict(input string name, input logic req, input logic [31:0] pc);
      logic [7:0] idx;
      logic [5:0] b;
      logic       hit, tk;
      idx = pc[9:2] ^ m_bhr;
      b   = pc[7:2];
      hit = m_ready && m_bv[b] && (m_tag[b] == pc[31:8]);
      tk  = req && hit && (m_unc[b] || m_pt[idx][1]);
      return mk(name, tk, tk ? m_tgt[b] : pc + 32'd4, idx);
   endfunction

   function automatic void m_update(input logic [31:0] pc, input logic [7:0] idx,
                                    input logic cond, input logic tk, input logic [31:0] tgt);
      logic [5:0] b;
      if (!m_ready) return;
      if (cond) begin
         if (tk && m_pt[idx] != 2'b11) m_pt[idx] = m_pt[idx] + 2'd1;
         else if (!tk && m_pt[idx] != 2'b00) m_pt[idx] = m_pt[idx] - 2'd1;
         m_bhr = {m_bhr[6:0], tk};
      end
      if (tk || !cond) begin
         b = pc[7:2];
         m_bv[b] = 1'b1; m_tag[b] = pc[31:8]; m_tgt[b] = tgt; m_unc[b] = !cond;
      end
   endfunction

   function automatic void m_reset();
      m_ready = 1'b0;
      m_bhr   = 8'h00;
   endfunction

   function automatic void m_init_done();
      for (int i = 0; i < 256; i++) m_pt[i] = 2'b01;
      for (int i = 0; i < 64; i++) m_bv[i] = 1'b0;
      m_ready = 1'b1;
   endfunction

   // Drive a single update for one edge; phase is posedge+1 on entry and exit.
   task automatic do_update(input logic [31:0] pc, input logic [7:0] idx, input logic cond,
                            input logic tk, input logic [31:0] tgt);
      upd_valid = 1'b1; upd_pc = pc; upd_pt_idx = idx; upd_is_cond = cond;
      upd_taken = tk; upd_target = tgt;
      m_update(pc, idx, cond, tk, tgt);
      @(posedge clk); #1;
      upd_valid = 1'b0;
   endtask

   task automatic test_reset();
      int   zeros = 0;
      int   bad = 0;
      logic seen = 1'b0;
      reset = 1'b1; fe_req = 1'b1; fe_pc = 32'h0000_1234;
      @(posedge clk); #1;
      @(negedge clk);
      tests_run++;
      if (ready !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 32'h0000_1238) begin
         tests_failed++;
         $display("FAIL reset_hold: ready=%b taken=%b target=%h, required ready=0 taken=0 target=00001238",
                  ready, pred_taken, pred_target);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      m_reset();
      for (int c = 0; c < 400 && !seen; c++) begin
         fe_pc = $urandom & 32'hFFFF_FFFC;
         @(negedge clk);
         if (ready === 1'b1) seen = 1'b1;
         else begin
            zeros++;
            if (pred_taken !== 1'b0) bad++;
         end
         @(posedge clk); #1;
      end
      tests_run++;
      if (!seen || zeros != 256) begin
         tests_failed++;
         $display("FAIL init_length: ready seen=%b after %0d not-ready cycles, required 256", seen, zeros);
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL init_no_pred: %0d cycles with pred_taken=1 during INIT, required 0", bad);
      end
      m_init_done();
   endtask

   task automatic test_uncond_jump();
      exp_t e;
      do_update(32'h100, 8'h40, 1'b0, 1'b1, 32'h300);
      fe_req = 1'b1; fe_pc = 32'h100;
      exp_q.push_back(mk("jump_hit", 1'b1, 32'h300, 8'h40));
      @(negedge clk);
      e = exp_q.pop_front();
      tests_run++;
      if (pred_taken !== e.taken || pred_target !== e.target || pred_pt_idx !== e.idx) begin
         tests_failed++;
         $display("FAIL %s: got taken=%b target=%h idx=%h, required taken=%b target=%h idx=%h",
                  e.name, pred_taken, pred_target, pred_pt_idx, e.taken, e.target, e.idx);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_same_cycle();
      exp_t e;
      fe_req = 1'b1; fe_pc = 32'h180;
      upd_valid = 1'b1; upd_pc = 32'h180; upd_pt_idx = 8'h60; upd_is_cond = 1'b0;
      upd_taken = 1'b1; upd_target = 32'h500;
      exp_q.push_back(mk("same_cycle_old", 1'b0, 32'h184, 8'h60));
      @(negedge clk);
      e = exp_q.pop_front();
      tests_run++;
      if (pred_taken !== e.taken || pred_target !== e.target || pred_pt_idx !== e.idx) begin
         tests_failed++;
         $display("FAIL %s: got taken=%b target=%h idx=%h, required taken=%b target=%h idx=%h",
                  e.name, pred_taken, pred_target, pred_pt_idx, e.taken, e.target, e.idx);
      end
      m_update(32'h180, 8'h60, 1'b0, 1'b1, 32'h500);
      @(posedge clk); #1;
      upd_valid = 1'b0;
      exp_q.push_back(mk("same_cycle_new", 1'b1, 32'h500, 8'h60));
      @(negedge clk);
      e = exp_q.pop_front();
      tests_run++;
      if (pred_taken !== e.taken || pred_target !== e.target || pred_pt_idx !== e.idx) begin
         tests_failed++;
         $display("FAIL %s: got taken=%b target=%h idx=%h, required taken=%b target=%h idx=%h",
                  e.name, pred_taken, pred_target, pred_pt_idx, e.taken, e.target, e.idx);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_alias();
      exp_t e;
      logic [31:0] pcs [2];
      pcs[0] = 32'h200; pcs[1] = 32'h100;
      exp_q.push_back(mk("alias_miss", 1'b0, 32'h204, 8'h80));
      exp_q.push_back(mk("alias_orig_hit", 1'b1, 32'h300, 8'h40));
      for (int i = 0; i < 2; i++) begin
         fe_req = 1'b1; fe_pc = pcs[i];
         @(negedge clk);
         e = exp_q.pop_front();
         tests_run++;
         if (pred_taken !== e.taken || pred_target !== e.target || pred_pt_idx !== e.idx) begin
            tests_failed++;
            $display("FAIL %s: got taken=%b target=%h idx=%h, required taken=%b target=%h idx=%h",
                     e.name, pred_taken, pred_target, pred_pt_idx, e.taken, e.target, e.idx);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_cond_bhr();
      exp_t e;
      do_update(32'h100, 8'h40, 1'b1, 1'b1, 32'h340);
      fe_req = 1'b1; fe_pc = 32'h100;
      exp_q.push_back(mk("cond_bhr_shift", 1'b0, 32'h104, 8'h41));
      @(negedge clk);
      e = exp_q.pop_front();
      tests_run++;
      if (pred_taken !== e.taken || pred_target !== e.target || pred_pt_idx !== e.idx) begin
         tests_failed++;
         $display("FAIL %s: got taken=%b target=%h idx=%h, required taken=%b target=%h idx=%h",
                  e.name, pred_taken, pred_target, pred_pt_idx, e.taken, e.target, e.idx);
      end
      @(posedge clk); #1;
   endtask

   // Counter at index 5 goes 10,11,11,11 then 10,01; each step is observed
   // through a lookup whose PC is chosen so that pc[9:2]^BHR == 5.
   task automatic test_counter();
      exp_t        e;
      logic        exp_tk [6];
      logic [7:0]  b1, b2;
      logic [31:0] p, t;
      exp_tk[0] = 1'b1; exp_tk[1] = 1'b1; exp_tk[2] = 1'b1;
      exp_tk[3] = 1'b1; exp_tk[4] = 1'b1; exp_tk[5] = 1'b0;
      for (int s = 0; s < 6; s++) begin
         t = 32'h1000 + 32'(s) * 32'd16;
         if (s < 4) begin
            b2 = {m_bhr[6:0], 1'b1};
            p  = {22'b0, 8'd5 ^ b2, 2'b00};
            do_update(p, 8'd5, 1'b1, 1'b1, t);
         end else begin
            b1 = {m_bhr[6:0], 1'b1};
            b2 = {b1[6:0], 1'b0};
            p  = {22'b0, 8'd5 ^ b2, 2'b00};
            do_update(p, 8'hAA, 1'b1, 1'b1, t);
            do_update(p, 8'd5, 1'b1, 1'b0, t + 32'd4);
         end
         fe_req = 1'b1; fe_pc = p;
         exp_q.push_back(mk($sformatf("counter_step%0d", s), exp_tk[s],
                            exp_tk[s] ? t : p + 32'd4, 8'd5));
         @(negedge clk);
         e = exp_q.pop_front();
         tests_run++;
         if (pred_taken !== e.taken || pred_target !== e.target || pred_pt_idx !== e.idx) begin
            tests_failed++;
            $display("FAIL %s: got taken=%b target=%h idx=%h, required taken=%b target=%h idx=%h",
                     e.name, pred_taken, pred_target, pred_pt_idx, e.taken, e.target, e.idx);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   zeros = 0;
      int   bad = 0;
      logic seen = 1'b0;
      do_update(32'h100, 8'h40, 1'b0, 1'b1, 32'h300);
      fe_req = 1'b1; fe_pc = 32'h100;
      reset = 1'b1;
      @(negedge clk);
      tests_run++;
      if (ready !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 32'h104) begin
         tests_failed++;
         $display("FAIL reset_gates_hit: ready=%b taken=%b target=%h, required ready=0 taken=0 target=00000104",
                  ready, pred_taken, pred_target);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      m_reset();
      repeat (50) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int c = 0; c < 400 && !seen; c++) begin
         if (c == 100) begin
            upd_valid = 1'b1; upd_pc = 32'h100; upd_pt_idx = 8'h40;
            upd_is_cond = 1'b0; upd_taken = 1'b1; upd_target = 32'h700;
         end else if (c == 101) begin
            upd_is_cond = 1'b1;
         end else begin
            upd_valid = 1'b0;
         end
         @(negedge clk);
         if (ready === 1'b1) seen = 1'b1;
         else begin
            zeros++;
            if (pred_taken !== 1'b0) bad++;
         end
         @(posedge clk); #1;
      end
      upd_valid = 1'b0;
      tests_run++;
      if (!seen || zeros != 256) begin
         tests_failed++;
         $display("FAIL reinit_length: ready seen=%b after %0d not-ready cycles, required 256", seen, zeros);
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL reinit_no_pred: %0d cycles with pred_taken=1 during INIT, required 0", bad);
      end
      m_init_done();
      fe_pc = 32'h100;
      exp_q.push_back(mk("reinit_miss", 1'b0, 32'h104, 8'h40));
      @(negedge clk);
      e = exp_q.pop_front();
      tests_run++;
      if (pred_taken !== e.taken || pred_target !== e.target || pred_pt_idx !== e.idx) begin
         tests_failed++;
         $display("FAIL %s: got taken=%b target=%h idx=%h, required taken=%b target=%h idx=%h",
                  e.name, pred_taken, pred_target, pred_pt_idx, e.taken, e.target, e.idx);
      end
      @(posedge clk); #1;
   endtask

   // Random concurrent lookups and updates, checked against the model.
   task automatic test_back_to_back();
      exp_t e;
      int   errs = 0;
      for (int i = 0; i < 80; i++) begin
         fe_req = ($urandom_range(0, 7) != 0);
         fe_pc  = 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2));
         upd_valid   = 1'($urandom_range(0, 1));
         upd_pc      = 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2));
         upd_is_cond = 1'($urandom_range(0, 1));
         upd_taken   = 1'($urandom_range(0, 1));
         upd_target  = $urandom & 32'hFFFF_FFFC;
         upd_pt_idx  = ($urandom_range(0, 1) != 0) ? (upd_pc[9:2] ^ m_bhr) : 8'($urandom);
         exp_q.push_back(m_predict($sformatf("b2b[%0d]", i), fe_req, fe_pc));
         @(negedge clk);
         e = exp_q.pop_front();
         tests_run++;
         if (pred_taken !== e.taken || pred_target !== e.target || pred_pt_idx !== e.idx) begin
            tests_failed++;
            errs++;
            if (errs <= 10)
               $display("FAIL %s: got taken=%b target=%h idx=%h, required taken=%b target=%h idx=%h",
                        e.name, pred_taken, pred_target, pred_pt_idx, e.taken, e.target, e.idx);
         end
         if (upd_valid) m_update(upd_pc, upd_pt_idx, upd_is_cond, upd_taken, upd_target);
         @(posedge clk); #1;
      end
      upd_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; fe_req = 1'b0; fe_pc = '0;
      upd_valid = 1'b0; upd_pc = '0; upd_pt_idx = '0;
      upd_is_cond = 1'b0; upd_taken = 1'b0; upd_target = '0;
      test_reset();
      test_uncond_jump();
      test_same_cycle();
      test_alias();
      test_cond_bhr();
      test_counter();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
